// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key constants for the pushbutton keypad
package keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } kp_state_t;

    localparam int NUM_PB = 21;

    localparam logic [4:0] KEY_ENTER = 5'd16;
    localparam logic [4:0] KEY_BKSP  = 5'd17;
    localparam logic [4:0] KEY_CLR   = 5'd18;

endpackage

// File: rtl/pb_sync.sv
// rtl/pb_sync.sv - parameterized-width two-flop synchronizer with async reset
module pb_sync #(
    parameter int WIDTH = 1
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_keypad.sv
// rtl/pb_keypad.sv - debounced priority keypad with hex entry register
module pb_keypad
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 2,
    parameter int DIGITS   = 8
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic [20:0]           pb,
    output logic [4:0]            keycode,
    output logic                  strobe,
    output logic                  held,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            count,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [3:0] DMAX    = 4'(DIGITS);

    logic [NUM_PB-1:0] pbs;
    logic [4:0]        enc;
    logic              any;
    kp_state_t         state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [4:0]        cand, cand_n;
    logic              accept;

    pb_sync #(.WIDTH(NUM_PB)) u_sync (
        .hz100 (hz100),
        .reset (reset),
        .d     (pb),
        .q     (pbs)
    );

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            if (pbs[i]) enc = 5'(i);
        end
    end

    assign any  = |pbs;
    assign held = (state == S_PRESSED) || (state == S_RELEASE);

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (any) begin
                    cand_n  = enc;
                    cnt_n   = '0;
                    state_n = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!any || enc != cand) begin
                    state_n = S_IDLE;
                end else if (cnt == DB_LAST) begin
                    accept  = 1'b1;
                    state_n = S_PRESSED;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            S_PRESSED: begin
                if (!any) begin
                    cnt_n   = '0;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (any) begin
                    state_n = S_PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            keycode <= '0;
            strobe  <= 1'b0;
            entry   <= '0;
            count   <= '0;
            value   <= '0;
            valid   <= 1'b0;
        end else begin
            strobe <= accept;
            valid  <= 1'b0;
            if (accept) begin
                keycode <= cand;
                if (!cand[4]) begin
                    entry <= {entry[4*DIGITS-5:0], cand[3:0]};
                    count <= (count == DMAX) ? count : count + 4'd1;
                end else if (cand == KEY_BKSP) begin
                    entry <= entry >> 4;
                    count <= (count == 4'd0) ? count : count - 4'd1;
                end else if (cand == KEY_CLR) begin
                    entry <= '0;
                    count <= '0;
                end else if (cand == KEY_ENTER) begin
                    value <= entry;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pb_keypad.sv
// tb/tb_pb_keypad.sv - scoreboard bench for pb_keypad
module tb_pb_keypad;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] pb    = '0;
    logic [4:0]  keycode;
    logic        strobe;
    logic        held;
    logic [31:0] entry;
    logic [3:0]  count;
    logic [31:0] value;
    logic        valid;

    pb_keypad #(.DEBOUNCE(2), .DIGITS(8)) dut (
        .hz100   (hz100),
        .reset   (reset),
        .pb      (pb),
        .keycode (keycode),
        .strobe  (strobe),
        .held    (held),
        .entry   (entry),
        .count   (count),
        .value   (value),
        .valid   (valid)
    );

    always #5 hz100 = ~hz100;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] ent;
        logic [3:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] val_q[$];
    int          cyc   = 0;
    int          nchk  = 0;
    int          nerr  = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_valid  = 1'b0;

    logic [31:0] digit_exp [9] = '{32'h51, 32'h512, 32'h5123, 32'h51234, 32'h512345,
                                   32'h5123456, 32'h51234567, 32'h12345678, 32'h23456789};
    logic [3:0]  digit_cnt [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8};

    always @(posedge hz100) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises strobe or valid.
    always @(negedge hz100) begin
        if (strobe) begin
            chk("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_strobe: got keycode %0d, expected no event", keycode);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("keycode", {27'd0, keycode}, {27'd0, e.code});
                chk("entry",   entry, e.ent);
                chk("count",   {28'd0, count}, {28'd0, e.cnt});
                chk("latency", cyc, e.cyc);
                chk("held_at_strobe", {31'd0, held}, 32'd1);
            end
        end
        if (valid) begin
            chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            if (val_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_valid: got value %h, expected no update", value);
            end else begin
                chk("value", value, val_q.pop_front());
            end
        end
        prev_strobe = strobe;
        prev_valid  = valid;
    end

    task automatic expect_key(input logic [4:0] code, input logic [31:0] e, input logic [3:0] c);
        exp_t x;
        x.code = code;
        x.ent  = e;
        x.cnt  = c;
        x.cyc  = cyc + 5;
        exp_q.push_back(x);
    endtask

    task automatic press(input logic [20:0] m, input logic [4:0] code,
                         input logic [31:0] e, input logic [3:0] c);
        @(negedge hz100);
        expect_key(code, e, c);
        pb = m;
        repeat (10) @(negedge hz100);
        pb = '0;
        repeat (6) @(negedge hz100);
        chk("held_after_release", {31'd0, held}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge hz100);
        chk("reset_entry",   entry, 32'd0);
        chk("reset_count",   {28'd0, count}, 32'd0);
        chk("reset_keycode", {27'd0, keycode}, 32'd0);
        chk("reset_held",    {31'd0, held}, 32'd0);
        chk("reset_value",   value, 32'd0);
        reset = 1'b0;

        press(21'd1 << 5, 5'd5, 32'h5, 4'd1);

        @(negedge hz100);
        pb = 21'd1 << 7;
        repeat (2) @(negedge hz100);
        pb = '0;
        repeat (8) @(negedge hz100);
        chk("glitch_entry", entry, 32'h5);
        chk("glitch_count", {28'd0, count}, 32'd1);

        for (int i = 0; i < 9; i++)
            press(21'd1 << (i + 1), 5'(i + 1), digit_exp[i], digit_cnt[i]);
        val_q.push_back(32'h23456789);
        press(21'd1 << 16, 5'd16, 32'h23456789, 4'd8);

        press(21'd1 << 18, 5'd18, 32'h0, 4'd0);
        press(21'd1 << 10, 5'd10, 32'hA, 4'd1);
        press(21'd1 << 11, 5'd11, 32'hAB, 4'd2);
        press(21'd1 << 17, 5'd17, 32'hA, 4'd1);
        press(21'd1 << 17, 5'd17, 32'h0, 4'd0);
        press(21'd1 << 17, 5'd17, 32'h0, 4'd0);

        press(21'd1 << 7, 5'd7, 32'h7, 4'd1);
        press((21'd1 << 3) | (21'd1 << 18), 5'd18, 32'h0, 4'd0);

        @(negedge hz100);
        expect_key(5'd4, 32'h4, 4'd1);
        pb = 21'd1 << 4;
        repeat (7) @(negedge hz100);
        reset = 1'b1;
        #1;
        chk("midreset_entry",   entry, 32'd0);
        chk("midreset_count",   {28'd0, count}, 32'd0);
        chk("midreset_keycode", {27'd0, keycode}, 32'd0);
        chk("midreset_held",    {31'd0, held}, 32'd0);
        chk("midreset_value",   value, 32'd0);
        @(negedge hz100);
        reset = 1'b0;
        expect_key(5'd4, 32'h4, 4'd1);
        repeat (10) @(negedge hz100);
        pb = '0;
        repeat (6) @(negedge hz100);

        press(21'd1 << 20, 5'd20, 32'h4, 4'd1);

        repeat (5) @(negedge hz100);
        chk("pending_strobes", exp_q.size(), 32'd0);
        chk("pending_values",  val_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
